alu_bus_unit: RTL and testbench

//  CPU datapath core: 8-way bus mux feeding the B operand of an ALU, plus a registered Z/C/S/V flag register.

---
 rtl/alu_bus_unit_if.sv | 31 +++
 rtl/alu_bus_unit.sv | 97 +++++++++
 tb/tb_alu_bus_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_bus_unit_if.sv
// Bus/ALU signal bundle for alu_bus_unit.
// master drives sources, select, accumulator and opcode; slave returns results and flags.
interface alu_bus_unit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in0, in1, in2, in3;
    logic [WIDTH-1:0] in4, in5, in6, in7;
    logic [2:0]       sel;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] acc;
    logic [2:0]       op;
    logic [WIDTH-1:0] result;
    logic             zero, carry, sign, overflow;
    logic             z_flag, c_flag, s_flag, v_flag;

    modport master (
        output in0, in1, in2, in3, in4, in5, in6, in7,
        output sel, acc, op,
        input  bus, result,
        input  zero, carry, sign, overflow,
        input  z_flag, c_flag, s_flag, v_flag
    );

    modport slave (
        input  in0, in1, in2, in3, in4, in5, in6, in7,
        input  sel, acc, op,
        output bus, result,
        output zero, carry, sign, overflow,
        output z_flag, c_flag, s_flag, v_flag
    );
endinterface

// File: rtl/alu_bus_unit.sv
// 8-way bus mux feeding ALU operand B, with a registered Z/C/S/V flag register.
// Define ALU_LOGIC_OPS_EN to enable AND/OR/XOR/SHL/SHR on opcodes 3-7.
module alu_bus_unit #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_bus_unit_if.slave io
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] bus_o;
    logic [WIDTH-1:0] res;
    logic             cy, ov, wr;
    logic [3:0]       flags_d, flags_q;

    always_comb begin
        bus_o = '0;
        case (io.sel)
            3'd0: bus_o = io.in0;
            3'd1: bus_o = io.in1;
            3'd2: bus_o = io.in2;
            3'd3: bus_o = io.in3;
            3'd4: bus_o = io.in4;
            3'd5: bus_o = io.in5;
            3'd6: bus_o = io.in6;
            3'd7: bus_o = io.in7;
            default: bus_o = '0;
        endcase
    end

    // wr marks opcodes whose flags are latched; PASS-like codes leave it low
    always_comb begin
        res = bus_o;
        cy  = 1'b0;
        ov  = 1'b0;
        wr  = 1'b0;
        case (io.op)
            3'd1: begin
                {cy, res} = {1'b0, io.acc} + {1'b0, bus_o};
                ov = (io.acc[MSB] == bus_o[MSB]) && (res[MSB] != io.acc[MSB]);
                wr = 1'b1;
            end
            3'd2: begin
                res = io.acc - bus_o;
                cy  = (io.acc >= bus_o);
                ov  = (io.acc[MSB] != bus_o[MSB]) && (res[MSB] != io.acc[MSB]);
                wr  = 1'b1;
            end
`ifdef ALU_LOGIC_OPS_EN
            3'd3: begin
                res = io.acc & bus_o;
                wr  = 1'b1;
            end
            3'd4: begin
                res = io.acc | bus_o;
                wr  = 1'b1;
            end
            3'd5: begin
                res = io.acc ^ bus_o;
                wr  = 1'b1;
            end
            3'd6: begin
                res = {io.acc[MSB-1:0], 1'b0};
                cy  = io.acc[MSB];
                wr  = 1'b1;
            end
            3'd7: begin
                res = {1'b0, io.acc[MSB:1]};
                cy  = io.acc[0];
                wr  = 1'b1;
            end
`endif
            default: begin
                res = bus_o;
            end
        endcase
    end

    assign flags_d = wr ? {(res == '0), cy, res[MSB], ov} : flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= 4'b0000;
        else        flags_q <= flags_d;
    end

    assign io.bus      = bus_o;
    assign io.result   = res;
    assign io.zero     = (res == '0);
    assign io.carry    = cy;
    assign io.sign     = res[MSB];
    assign io.overflow = ov;
    assign io.z_flag   = flags_q[3];
    assign io.c_flag   = flags_q[2];
    assign io.s_flag   = flags_q[1];
    assign io.v_flag   = flags_q[0];
endmodule

// File: tb/tb_alu_bus_unit.sv
// Directed bench for alu_bus_unit: mux sweep, ADD/SUB flags, hold, async reset.
// Expected values are hand-computed constants.
module tb_alu_bus_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_bus_unit_if #(.WIDTH(8)) bus_if ();

    alu_bus_unit #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (bus_if.slave)
    );

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b);
        @(negedge clk);
        bus_if.op  = o;
        bus_if.acc = a;
        bus_if.in3 = b;
        bus_if.sel = 3'd3;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_comb(input string tag, input logic [7:0] r,
                            input logic z, input logic c,
                            input logic s, input logic v);
        check({tag, ".res"}, bus_if.result, r);
        check({tag, ".Z"}, {7'd0, bus_if.zero}, {7'd0, z});
        check({tag, ".C"}, {7'd0, bus_if.carry}, {7'd0, c});
        check({tag, ".S"}, {7'd0, bus_if.sign}, {7'd0, s});
        check({tag, ".V"}, {7'd0, bus_if.overflow}, {7'd0, v});
    endtask

    task automatic chk_reg(input string tag, input logic z, input logic c,
                           input logic s, input logic v);
        check({tag, ".zf"}, {7'd0, bus_if.z_flag}, {7'd0, z});
        check({tag, ".cf"}, {7'd0, bus_if.c_flag}, {7'd0, c});
        check({tag, ".sf"}, {7'd0, bus_if.s_flag}, {7'd0, s});
        check({tag, ".vf"}, {7'd0, bus_if.v_flag}, {7'd0, v});
    endtask

    task automatic chk_lt(input string tag, input logic exp);
        check(tag, {7'd0, bus_if.s_flag ^ bus_if.v_flag}, {7'd0, exp});
    endtask

    initial begin
        bus_if.in0 = 8'h10; bus_if.in1 = 8'h11;
        bus_if.in2 = 8'h12; bus_if.in3 = 8'h13;
        bus_if.in4 = 8'h14; bus_if.in5 = 8'h15;
        bus_if.in6 = 8'h16; bus_if.in7 = 8'h17;
        bus_if.sel = 3'd0;
        bus_if.acc = 8'h00;
        bus_if.op  = 3'd1;

        #12;
        chk_reg("reset", 1'b0, 1'b0, 1'b0, 1'b0);

        bus_if.op = 3'd0;
        for (int i = 0; i < 8; i++) begin
            bus_if.sel = i[2:0];
            #1;
            check($sformatf("mux%0d", i), bus_if.bus, 8'h10 + 8'(i));
        end

        @(negedge clk);
        rst_n = 1'b1;

        drive(3'd1, 8'h7F, 8'h01);
        chk_comb("add7f", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk_reg("add7f", 1'b0, 1'b0, 1'b1, 1'b1);

        drive(3'd1, 8'hFF, 8'h01);
        chk_comb("addff", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_reg("addff", 1'b1, 1'b1, 1'b0, 1'b0);

        drive(3'd2, 8'h03, 8'h05);
        chk_comb("sub35", 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_reg("sub35", 1'b0, 1'b0, 1'b1, 1'b0);
        chk_lt("sub35.lt", 1'b1);

        drive(3'd2, 8'h80, 8'h01);
        chk_comb("sub80", 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_reg("sub80", 1'b0, 1'b1, 1'b0, 1'b1);
        chk_lt("sub80.lt", 1'b1);

        drive(3'd2, 8'h05, 8'h05);
        chk_comb("sub55", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_reg("sub55", 1'b1, 1'b1, 1'b0, 1'b0);

        drive(3'd0, 8'h01, 8'h02);
        check("pass.res", bus_if.result, 8'h02);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_reg($sformatf("hold%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
        end

`ifdef ALU_LOGIC_OPS_EN
        drive(3'd6, 8'h81, 8'h33);
        check("shl.res", bus_if.result, 8'h02);
        check("shl.C", {7'd0, bus_if.carry}, 8'h01);
        tick();
        chk_reg("shl", 1'b0, 1'b1, 1'b0, 1'b0);

        drive(3'd7, 8'h81, 8'h33);
        chk_comb("shr", 8'h40, 1'b0, 1'b1, 1'b0, 1'b0);

        drive(3'd3, 8'hF0, 8'h33);
        chk_comb("and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        drive(3'd6, 8'h81, 8'h33);
        check("op6.res", bus_if.result, 8'h33);
        tick();
        chk_reg("op6", 1'b1, 1'b1, 1'b0, 1'b0);
`endif

        drive(3'd2, 8'h05, 8'h05);
        tick();
        chk_reg("preset", 1'b1, 1'b1, 1'b0, 1'b0);

        // assert reset mid-cycle; flags must clear before the next edge
        drive(3'd1, 8'h7F, 8'h01);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reg("rstasync", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst.res", bus_if.result, 8'h80);
        tick();
        tick();
        chk_reg("rsthold", 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_reg("release", 1'b0, 1'b0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
